serial_sub_ctrl: RTL



---
 rtl/serial_sub_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor controller: runs one two-stage half-subtractor cell
// over the operands LSB first, one bit per clock, and reports Diff = A - B and Bor.
module serial_sub_ctrl #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Diff,
  output logic         Bor
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bin_q, bin_d;
  logic          bor_q, bor_d;

  logic d1, br1, d, br2, bout, last_bit;

  // Shared bit cell: two cascaded half-subtractors.
  assign d1       = a_q[0] ^ b_q[0];
  assign br1      = ~a_q[0] & b_q[0];
  assign d        = d1 ^ bin_q;
  assign br2      = ~d1 & bin_q;
  assign bout     = br1 | br2;
  assign last_bit = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bor_d   = bor_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        ready = 1'b1;
        done  = (state_q == StDone);
        state_d = StIdle;
        if (start) begin
          a_d     = A;
          b_d     = B;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy   = 1'b1;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        // LSB-first fill: after W shifts bit 0 has reached Diff[0].
        diff_d = {d, diff_q[W-1:1]};
        bin_d  = bout;
        cnt_d  = cnt_q + 1'b1;
        if (last_bit) begin
          bor_d   = bout;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= 1'b0;
      bor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bor_q   <= bor_d;
    end
  end

  assign Diff = diff_q;
  assign Bor  = bor_q;

endmodule
